// File: rtl/mem_copy_engine_if.sv
// Host-side bus of the ROM-to-RAM copy engine: copy request, status and RAM read port.
// The engine connects through the slave modport, the host through the master modport.
interface mem_copy_engine_if #(
  parameter int DATA_W = 16,
  parameter int ROM_AW = 4,
  parameter int RAM_AW = 2
);
  logic              start;
  logic [ROM_AW-1:0] src_addr;
  logic [RAM_AW-1:0] dst_addr;
  logic [RAM_AW:0]   count;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [RAM_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              error;

  modport master (
    output start, src_addr, dst_addr, count, rd_en, rd_addr,
    input  busy, done, rd_data, rd_valid, error
  );

  modport slave (
    input  start, src_addr, dst_addr, count, rd_en, rd_addr,
    output busy, done, rd_data, rd_valid, error
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Copies a range of a fixed internal ROM into a small RAM, one word per two cycles.
// Define MEM_COPY_VERIFY_EN to add a read-back compare pass that drives the sticky error flag.
module mem_copy_engine #(
  parameter int DATA_W = 16,
  parameter int ROM_AW = 4,
  parameter int RAM_AW = 2
) (
  input logic             clock,
  input logic             reset,
  mem_copy_engine_if.slave bus
);
  localparam int              RAM_DEPTH = 1 << RAM_AW;
  localparam logic [RAM_AW:0] CNT_MAX   = (RAM_AW+1)'(RAM_DEPTH);
  localparam logic [RAM_AW:0] CNT_ONE   = (RAM_AW+1)'(1);
  localparam logic [RAM_AW:0] CNT_ZERO  = (RAM_AW+1)'(0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3
`ifdef MEM_COPY_VERIFY_EN
    , VRD  = 3'd4
    , VCMP = 3'd5
`endif
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [ROM_AW-1:0] src_r;
  logic [RAM_AW-1:0] dst_r;
  logic [RAM_AW:0]   rem_r;
  logic [DATA_W-1:0] rom_q_r;
  logic [DATA_W-1:0] ram_r [RAM_DEPTH];
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic [RAM_AW:0]   clamp_s;
`ifdef MEM_COPY_VERIFY_EN
  logic [ROM_AW-1:0] base_src_r;
  logic [RAM_AW-1:0] base_dst_r;
  logic [RAM_AW:0]   base_cnt_r;
  logic [DATA_W-1:0] ram_q_r;
  logic              error_r;
`endif

  // ROM contents: identity, except the top word which holds 'h69.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ROM_AW-1:0] a);
    logic [31:0] v;
    if (a == {ROM_AW{1'b1}}) begin
      v = 32'h0000_0069;
    end else begin
      v = 32'(a);
    end
    return v[DATA_W-1:0];
  endfunction

  // Requested word count saturated to the RAM depth.
  always_comb begin
    clamp_s = bus.count;
    if (bus.count > CNT_MAX) begin
      clamp_s = CNT_MAX;
    end else begin
      clamp_s = bus.count;
    end
  end

  // Copy sequencer with registered busy/done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      src_r   <= {ROM_AW{1'b0}};
      dst_r   <= {RAM_AW{1'b0}};
      rem_r   <= CNT_ZERO;
      rom_q_r <= {DATA_W{1'b0}};
`ifdef MEM_COPY_VERIFY_EN
      base_src_r <= {ROM_AW{1'b0}};
      base_dst_r <= {RAM_AW{1'b0}};
      base_cnt_r <= CNT_ZERO;
      ram_q_r    <= {DATA_W{1'b0}};
      error_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            src_r  <= bus.src_addr;
            dst_r  <= bus.dst_addr;
            rem_r  <= clamp_s;
            busy_r <= 1'b1;
`ifdef MEM_COPY_VERIFY_EN
            base_src_r <= bus.src_addr;
            base_dst_r <= bus.dst_addr;
            base_cnt_r <= clamp_s;
            error_r    <= 1'b0;
`endif
            if (clamp_s == CNT_ZERO) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= RD;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        RD: begin
          rom_q_r <= rom_word(src_r);
          state_r <= WR;
        end
        WR: begin
          src_r <= src_r + ROM_AW'(1);
          dst_r <= dst_r + RAM_AW'(1);
          rem_r <= rem_r - CNT_ONE;
          if (rem_r > CNT_ONE) begin
            state_r <= RD;
          end else begin
`ifdef MEM_COPY_VERIFY_EN
            // Rewind to the start of the range for the read-back pass.
            src_r   <= base_src_r;
            dst_r   <= base_dst_r;
            rem_r   <= base_cnt_r;
            state_r <= VRD;
`else
            state_r <= DONE;
            done_r  <= 1'b1;
`endif
          end
        end
`ifdef MEM_COPY_VERIFY_EN
        VRD: begin
          rom_q_r <= rom_word(src_r);
          ram_q_r <= ram_r[dst_r];
          state_r <= VCMP;
        end
        VCMP: begin
          if (rom_q_r != ram_q_r) begin
            error_r <= 1'b1;
          end else begin
            error_r <= error_r;
          end
          src_r <= src_r + ROM_AW'(1);
          dst_r <= dst_r + RAM_AW'(1);
          rem_r <= rem_r - CNT_ONE;
          if (rem_r > CNT_ONE) begin
            state_r <= VRD;
          end else begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
`endif
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // RAM array: cleared on reset, written only from WR.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        ram_r[i] <= {DATA_W{1'b0}};
      end
    end else if (state_r == WR) begin
      ram_r[dst_r] <= rom_q_r;
    end else begin
      ram_r[dst_r] <= ram_r[dst_r];
    end
  end

  // Host read port; refused while a copy owns the RAM so no write/read collision can occur.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else if (bus.rd_en && !busy_r) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= ram_r[bus.rd_addr];
    end else begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= rd_data_r;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
`ifdef MEM_COPY_VERIFY_EN
  assign bus.error    = error_r;
`else
  assign bus.error    = 1'b0;
`endif
endmodule
